// File: rtl/cory_pkg.sv
// Shared definitions for the cory stream source: FSM state encodings,
// pattern selectors and the Galois LFSR step used by the pattern generator.
package cory_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int          CORY_PAT_INC   = 0;
   localparam int          CORY_PAT_LFSR  = 1;
   localparam logic [31:0] CORY_LFSR_TAPS = 32'h8020_0003;

   // Right-shifting Galois form: the bit shifted out folds the taps back in.
   function automatic logic [31:0] lfsr_step(input logic [31:0] q);
      return q[0] ? ((q >> 1) ^ CORY_LFSR_TAPS) : (q >> 1);
   endfunction

   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] s);
      return (s == 32'd0) ? 32'd1 : s;
   endfunction

endpackage

// File: rtl/cory_lfsr.sv
// 32-bit Galois LFSR for the cory pattern generator; reset and load both
// reinitialise it from the (zero-substituted) seed.
module cory_lfsr
   import cory_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] q
);

   always_ff @(posedge clk) begin
      if (reset || load) begin
         q <= lfsr_seed_fix(seed);
      end else if (step) begin
         q <= lfsr_step(q);
      end
   end

endmodule

// File: rtl/cory_master.sv
// Behavioural valid/ready stream source: a start pulse launches a run of
// i_len beats with R idle cycles before each beat and an INC or LFSR pattern.
module cory_master
   import cory_pkg::*;
#(
   parameter int           N    = 64,
   parameter int           R    = 0,
   parameter int           P    = 0,
   parameter logic [N-1:0] SEED = '0,
   parameter int           V    = 0,
   parameter int           LW   = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_start,
   input  logic [LW-1:0] i_len,
   output logic          o_v,
   output logic [N-1:0]  o_d,
   input  logic          i_r,
   output logic          o_busy,
   output logic          o_done,
   output logic [LW-1:0] o_cnt
);

`ifdef SYNTHESIS
   assign o_v    = 1'b0;
   assign o_d    = '0;
   assign o_busy = 1'b0;
   assign o_done = 1'b0;
   assign o_cnt  = '0;
`else
   localparam bit          HAS_GAP   = (R > 0);
   localparam int          GW        = (R > 1) ? $clog2(R) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((R > 0) ? R - 1 : 0);
   localparam logic [31:0] LFSR_SEED = 32'(SEED);

   state_t        state, next_state;
   logic [LW-1:0] rem, cnt;
   logic [GW-1:0] gap;
   logic [N-1:0]  inc_word, lfsr_word, word;
   logic [31:0]   lfsr_q;
   logic          load, accept;

   assign load   = (state == IDLE) && i_start;
   assign accept = (state == SEND) && i_r;

   cory_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .seed  (LFSR_SEED),
      .step  (accept && (P == CORY_PAT_LFSR)),
      .q     (lfsr_q)
   );

   // Replicate the 32-bit LFSR across the full word (truncates when N < 32).
   always_comb begin
      lfsr_word = '0;
      for (int i = 0; i < N; i++) begin
         lfsr_word[i] = lfsr_q[i % 32];
      end
   end

   assign word  = (P == CORY_PAT_LFSR) ? lfsr_word : inc_word;
   assign o_d   = o_v ? word : '0;
   assign o_cnt = cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rem   <= '0;
         cnt   <= '0;
         gap   <= '0;
      end else begin
         state <= next_state;
         if (load) begin
            rem <= i_len;
            cnt <= '0;
            gap <= '0;
         end else if (accept) begin
            rem <= rem - LW'(1);
            cnt <= cnt + LW'(1);
            gap <= '0;
         end else if (state == GAP) begin
            gap <= gap + GW'(1);
         end
      end
   end

   // Incrementing pattern register is pure data: no reset, only load/advance.
   always_ff @(posedge clk) begin
      if (load) begin
         inc_word <= SEED;
      end else if (accept) begin
         inc_word <= inc_word + N'(1);
      end
   end

   always_comb begin
      next_state = state;
      o_v        = 1'b0;
      o_done     = 1'b0;
      o_busy     = (state != IDLE);
      case (state)
         IDLE: begin
            if (i_start) begin
               if (i_len == '0)  next_state = DONE;
               else if (HAS_GAP) next_state = GAP;
               else              next_state = SEND;
            end
         end
         GAP: begin
            if (gap == GAP_LAST) next_state = SEND;
         end
         SEND: begin
            o_v = 1'b1;
            if (i_r) begin
               if (rem == LW'(1)) next_state = DONE;
               else if (HAS_GAP)  next_state = GAP;
               else               next_state = SEND;
            end
         end
         DONE: begin
            o_done     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   if (V == 2) begin : g_mon
`ifdef CORY_MON
      cory_stream_mon #(.N(N)) u_mon (
         .clk (clk),
         .v   (o_v),
         .d   (o_d),
         .r   (i_r)
      );
`endif
   end
`endif

endmodule

// File: tb/tb_cory_master.sv
// Bench for cory_master: four instances with different widths, gaps and
// patterns, checked against a beat-list model of the expected stream.
module tb_cory_master;

   localparam int          NS    [4] = '{64, 16, 8, 48};
   localparam int          RS    [4] = '{0, 2, 0, 1};
   localparam int          PS    [4] = '{0, 0, 1, 1};
   localparam logic [63:0] SEEDS [4] = '{64'h10, 64'hFFFE, 64'h0, 64'hACE1};

   logic        clk = 1'b0;
   logic        reset;
   logic        start [4];
   logic [15:0] lenv  [4];
   logic        r     [4];
   logic        v     [4];
   logic        busy  [4];
   logic        done  [4];
   logic [15:0] cnt   [4];
   logic [63:0] d64   [4];

   logic [63:0] d0w;
   logic [15:0] d1w;
   logic [7:0]  d2w;
   logic [47:0] d3w;
   logic [7:0]  cnt1w;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   logic [63:0] acc      [4][256];
   int          acc_n    [4];
   int          last_acc [4];
   int          done_n   [4];
   int          vcount   [4];
   int          stab_err;
   int          gap_err;
   logic        prev_v   [4];
   logic        prev_r   [4];
   logic [63:0] prev_d   [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   cory_master #(.N(64), .R(0), .P(0), .SEED(64'h10), .V(0), .LW(16)) dut0 (
      .clk(clk), .reset(reset), .i_start(start[0]), .i_len(lenv[0]), .o_v(v[0]),
      .o_d(d0w), .i_r(r[0]), .o_busy(busy[0]), .o_done(done[0]), .o_cnt(cnt[0]));
   cory_master #(.N(16), .R(2), .P(0), .SEED(16'hFFFE), .V(0), .LW(8)) dut1 (
      .clk(clk), .reset(reset), .i_start(start[1]), .i_len(lenv[1][7:0]), .o_v(v[1]),
      .o_d(d1w), .i_r(r[1]), .o_busy(busy[1]), .o_done(done[1]), .o_cnt(cnt1w));
   cory_master #(.N(8), .R(0), .P(1), .SEED(8'h00), .V(0), .LW(16)) dut2 (
      .clk(clk), .reset(reset), .i_start(start[2]), .i_len(lenv[2]), .o_v(v[2]),
      .o_d(d2w), .i_r(r[2]), .o_busy(busy[2]), .o_done(done[2]), .o_cnt(cnt[2]));
   cory_master #(.N(48), .R(1), .P(1), .SEED(48'hACE1), .V(0), .LW(16)) dut3 (
      .clk(clk), .reset(reset), .i_start(start[3]), .i_len(lenv[3]), .o_v(v[3]),
      .o_d(d3w), .i_r(r[3]), .o_busy(busy[3]), .o_done(done[3]), .o_cnt(cnt[3]));

   assign d64[0] = d0w;
   assign d64[1] = {48'd0, d1w};
   assign d64[2] = {56'd0, d2w};
   assign d64[3] = {16'd0, d3w};
   assign cnt[1] = {8'd0, cnt1w};

   // Stream observer: records accepted beats, done pulses, hold and gap violations.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) begin
            prev_v[i] = 1'b0;
         end else begin
            if (prev_v[i] && !prev_r[i] && (!v[i] || d64[i] !== prev_d[i])) stab_err++;
            if (v[i]) vcount[i]++;
            if (v[i] && r[i]) begin
               if (acc_n[i] > 0 && (cyc - last_acc[i]) <= RS[i]) gap_err++;
               if (acc_n[i] < 256) acc[i][acc_n[i]] = d64[i];
               acc_n[i]++;
               last_acc[i] = cyc;
            end
            if (done[i]) done_n[i]++;
            prev_v[i] = v[i];
            prev_r[i] = r[i];
            prev_d[i] = d64[i];
         end
      end
   end

   function automatic logic [63:0] model_word(input int idx, input int j);
      logic [63:0] s, w, mask;
      logic [31:0] x;
      s    = SEEDS[idx];
      w    = '0;
      mask = (NS[idx] == 64) ? '1 : ((64'd1 << NS[idx]) - 64'd1);
      if (PS[idx] == 0) begin
         w = s + 64'(j);
      end else begin
         x = s[31:0];
         if (x == 32'd0) x = 32'd1;
         for (int k = 0; k < j; k++) x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
         for (int b = 0; b < NS[idx]; b++) w[b] = x[b % 32];
      end
      return w & mask;
   endfunction

   function automatic int seq_errors(input int idx, input int len);
      int e = 0;
      for (int j = 0; j < len && j < 256; j++) begin
         if (acc[idx][j] !== model_word(idx, j)) e++;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      for (int i = 0; i < 4; i++) acc_n[i] = 0;
      stab_err = 0;
      gap_err  = 0;
   endtask

   task automatic wait_done(input int idx, input int d_before, input bit rnd, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (done_n[idx] != d_before) begin
            ok = 1'b1;
            break;
         end
         if (rnd) r[idx] = ($urandom_range(0, 3) != 0);
         tick();
      end
      r[idx] = 1'b1;
   endtask

   task automatic drive_run(input int idx, input int len, input bit rnd, output bit ok);
      int d_before;
      d_before   = done_n[idx];
      start[idx] = 1'b1;
      lenv[idx]  = 16'(len);
      r[idx]     = 1'b1;
      tick();
      start[idx] = 1'b0;
      wait_done(idx, d_before, rnd, ok);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         vectors++; if (v[i] !== 1'b0) begin miscompares++; $display("FAIL reset_v[%0d]: got %b want 0", i, v[i]); end
         vectors++; if (d64[i] !== 64'd0) begin miscompares++; $display("FAIL reset_d[%0d]: got %0h want 0", i, d64[i]); end
         vectors++; if (busy[i] !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
         vectors++; if (done[i] !== 1'b0) begin miscompares++; $display("FAIL reset_done[%0d]: got %b want 0", i, done[i]); end
         vectors++; if (cnt[i] !== 16'd0) begin miscompares++; $display("FAIL reset_cnt[%0d]: got %0d want 0", i, cnt[i]); end
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_inc_stream();
      clear_obs();
      start[0] = 1'b1; lenv[0] = 16'd4; r[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      for (int j = 0; j < 4; j++) begin
         vectors++; if (v[0] !== 1'b1) begin miscompares++; $display("FAIL inc_v beat %0d: got %b want 1", j, v[0]); end
         vectors++; if (d64[0] !== 64'h10 + 64'(j)) begin miscompares++; $display("FAIL inc_d beat %0d: got %0h want %0h", j, d64[0], 64'h10 + 64'(j)); end
         tick();
      end
      vectors++; if (done[0] !== 1'b1) begin miscompares++; $display("FAIL inc_done: got %b want 1", done[0]); end
      vectors++; if (cnt[0] !== 16'd4) begin miscompares++; $display("FAIL inc_cnt: got %0d want 4", cnt[0]); end
      vectors++; if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL inc_busy_done: got %b want 1", busy[0]); end
      tick();
      vectors++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin miscompares++; $display("FAIL inc_idle: busy %b done %b want 0 0", busy[0], done[0]); end
   endtask

   task automatic test_gap_pattern();
      logic exp_v [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
      clear_obs();
      start[1] = 1'b1; lenv[1] = 16'd3; r[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      for (int c = 0; c < 9; c++) begin
         vectors++; if (v[1] !== exp_v[c]) begin miscompares++; $display("FAIL gap_v cycle %0d: got %b want %b", c, v[1], exp_v[c]); end
         tick();
      end
      vectors++; if (done[1] !== 1'b1) begin miscompares++; $display("FAIL gap_done: got %b want 1", done[1]); end
      tick();
      vectors++; if (seq_errors(1, 3) != 0 || acc_n[1] != 3) begin miscompares++; $display("FAIL gap_words: %0d wrong of %0d got, want 0 wrong of 3", seq_errors(1, 3), acc_n[1]); end
   endtask

   task automatic test_backpressure();
      int  d_before;
      bit  ok;
      clear_obs();
      d_before = done_n[0];
      start[0] = 1'b1; lenv[0] = 16'd5; r[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      r[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         vectors++; if (v[0] !== 1'b1 || d64[0] !== 64'h11) begin miscompares++; $display("FAIL bp_hold %0d: v %b d %0h want 1 11", c, v[0], d64[0]); end
         tick();
      end
      r[0] = 1'b1;
      #1;
      vectors++; if (v[0] !== 1'b1 || d64[0] !== 64'h11) begin miscompares++; $display("FAIL bp_release: v %b d %0h want 1 11", v[0], d64[0]); end
      wait_done(0, d_before, 1'b0, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL bp_timeout: done seen %b want 1", ok); end
      vectors++; if (acc_n[0] != 5 || seq_errors(0, 5) != 0) begin miscompares++; $display("FAIL bp_words: %0d beats %0d wrong, want 5 beats 0 wrong", acc_n[0], seq_errors(0, 5)); end
      vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL bp_stable: %0d violations want 0", stab_err); end
   endtask

   task automatic test_lfsr();
      bit          ok;
      logic [63:0] first [4];
      clear_obs();
      drive_run(2, 4, 1'b0, ok);
      vectors++; if (!ok || acc_n[2] != 4) begin miscompares++; $display("FAIL lfsr_run: done %b beats %0d want 1 4", ok, acc_n[2]); end
      vectors++; if (acc[2][0] !== 64'h01) begin miscompares++; $display("FAIL lfsr_w0: got %0h want 01", acc[2][0]); end
      vectors++; if (acc[2][1] !== 64'h03) begin miscompares++; $display("FAIL lfsr_w1: got %0h want 03", acc[2][1]); end
      vectors++; if (seq_errors(2, 4) != 0) begin miscompares++; $display("FAIL lfsr_seq: %0d wrong want 0", seq_errors(2, 4)); end
      for (int j = 0; j < 4; j++) first[j] = acc[2][j];
      clear_obs();
      drive_run(2, 4, 1'b1, ok);
      for (int j = 0; j < 4; j++) begin
         vectors++; if (acc[2][j] !== first[j]) begin miscompares++; $display("FAIL lfsr_repeat %0d: got %0h want %0h", j, acc[2][j], first[j]); end
      end
      clear_obs();
      drive_run(3, 6, 1'b1, ok);
      vectors++; if (!ok || acc_n[3] != 6 || seq_errors(3, 6) != 0) begin miscompares++; $display("FAIL lfsr_wide: done %b beats %0d wrong %0d want 1 6 0", ok, acc_n[3], seq_errors(3, 6)); end
   endtask

   task automatic test_zero_len();
      int vc;
      vc = vcount[0];
      start[0] = 1'b1; lenv[0] = 16'd0;
      tick();
      start[0] = 1'b0;
      vectors++; if (done[0] !== 1'b1 || v[0] !== 1'b0) begin miscompares++; $display("FAIL zero_done: done %b v %b want 1 0", done[0], v[0]); end
      vectors++; if (cnt[0] !== 16'd0 || busy[0] !== 1'b1) begin miscompares++; $display("FAIL zero_cnt: cnt %0d busy %b want 0 1", cnt[0], busy[0]); end
      tick();
      vectors++; if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin miscompares++; $display("FAIL zero_idle: done %b busy %b want 0 0", done[0], busy[0]); end
      vectors++; if (vcount[0] != vc) begin miscompares++; $display("FAIL zero_novalid: %0d valid cycles want 0", vcount[0] - vc); end
   endtask

   task automatic test_back_to_back();
      int d_before;
      bit ok;
      clear_obs();
      start[0] = 1'b1; lenv[0] = 16'd2; r[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      tick();
      vectors++; if (done[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %b want 1", done[0]); end
      start[0] = 1'b1; lenv[0] = 16'd3;
      tick();
      vectors++; if (busy[0] !== 1'b0 || v[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_ignored: busy %b v %b want 0 0", busy[0], v[0]); end
      d_before = done_n[0];
      tick();
      start[0] = 1'b0;
      vectors++; if (v[0] !== 1'b1 || d64[0] !== 64'h10) begin miscompares++; $display("FAIL b2b_restart: v %b d %0h want 1 10", v[0], d64[0]); end
      wait_done(0, d_before, 1'b0, ok);
      vectors++; if (!ok || acc_n[0] != 5 || acc[0][2] !== 64'h10 || acc[0][4] !== 64'h12) begin
         miscompares++; $display("FAIL b2b_words: done %b beats %0d w2 %0h w4 %0h want 1 5 10 12", ok, acc_n[0], acc[0][2], acc[0][4]);
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      clear_obs();
      start[0] = 1'b1; lenv[0] = 16'd10; r[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      vectors++; if (v[0] !== 1'b1 || d64[0] !== 64'h12) begin miscompares++; $display("FAIL rst_pre: v %b d %0h want 1 12", v[0], d64[0]); end
      tick();
      reset = 1'b0;
      vectors++; if (v[0] !== 1'b0 || cnt[0] !== 16'd0) begin miscompares++; $display("FAIL rst_after: v %b cnt %0d want 0 0", v[0], cnt[0]); end
      vectors++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin miscompares++; $display("FAIL rst_status: busy %b done %b want 0 0", busy[0], done[0]); end
      clear_obs();
      drive_run(0, 5, 1'b0, ok);
      vectors++; if (!ok || acc_n[0] != 5 || acc[0][0] !== 64'h10) begin miscompares++; $display("FAIL rst_restart: done %b beats %0d w0 %0h want 1 5 10", ok, acc_n[0], acc[0][0]); end
   endtask

   task automatic test_random();
      bit ok;
      int len;
      for (int rep = 0; rep < 5; rep++) begin
         for (int idx = 0; idx < 4; idx++) begin
            clear_obs();
            len = $urandom_range(1, 60);
            drive_run(idx, len, 1'b1, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL rnd_timeout dut%0d: done %b want 1", idx, ok); end
            vectors++; if (acc_n[idx] != len || cnt[idx] !== 16'(len)) begin miscompares++; $display("FAIL rnd_count dut%0d: beats %0d cnt %0d want %0d", idx, acc_n[idx], cnt[idx], len); end
            vectors++; if (seq_errors(idx, len) != 0) begin miscompares++; $display("FAIL rnd_words dut%0d: %0d wrong want 0", idx, seq_errors(idx, len)); end
            vectors++; if (stab_err != 0 || gap_err != 0) begin miscompares++; $display("FAIL rnd_protocol dut%0d: hold %0d gap %0d want 0 0", idx, stab_err, gap_err); end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         start[i] = 1'b0; lenv[i] = 16'd0; r[i] = 1'b1;
         acc_n[i] = 0; last_acc[i] = 0; done_n[i] = 0; vcount[i] = 0;
         prev_v[i] = 1'b0; prev_r[i] = 1'b0; prev_d[i] = 64'd0;
      end
      stab_err = 0;
      gap_err  = 0;
      test_reset();
      test_inc_stream();
      test_gap_pattern();
      test_backpressure();
      test_lfsr();
      test_zero_len();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
